// File: rtl/dmem_arbiter.sv
// Two-master (CPU, host) arbiter in front of a single-port synchronous data RAM.
// Every access takes IDLE -> ACCESS -> DONE; ties go round-robin, host_lock masks the CPU.
module dmem_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  input  logic          host_lock,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          owner_q;       // 1 = host owns the transaction in flight
  logic          last_grant_q;  // 1 = host was granted last
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] host_rdata_q;

  logic cpu_elig, host_elig, grant_any, grant_host, done;

  always_comb begin
    cpu_elig   = cpu_req & ~host_lock;
    host_elig  = host_req;
    grant_any  = cpu_elig | host_elig;
    // On a tie the side that was not granted last wins.
    grant_host = host_elig & (~cpu_elig | ~last_grant_q);
  end

  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle:   state_d = grant_any ? StAccess : StIdle;
      StAccess: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && grant_any) begin
        owner_q      <= grant_host;
        last_grant_q <= grant_host;
        we_q         <= grant_host ? host_we    : cpu_we;
        addr_q       <= grant_host ? host_addr  : cpu_addr;
        wdata_q      <= grant_host ? host_wdata : cpu_wdata;
      end
      if (state_q == StDone && !we_q) begin
        if (owner_q) host_rdata_q <= mem_rdata;
        else         cpu_rdata_q  <= mem_rdata;
      end
    end
  end

  always_comb begin
    done      = (state_q == StDone);
    mem_we    = (state_q == StAccess) & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    cpu_ack   = done & ~owner_q;
    host_ack  = done & owner_q;
    // Read data bypasses the holding register so it is valid during the ack cycle.
    cpu_rdata  = (cpu_ack  & ~we_q) ? mem_rdata : cpu_rdata_q;
    host_rdata = (host_ack & ~we_q) ? mem_rdata : host_rdata_q;
    cpu_stall  = cpu_req & ~cpu_ack;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected acks and RAM writes,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_dmem_arbiter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic       cpu_ack, cpu_stall;
  logic [7:0] cpu_rdata;
  logic       host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
  logic [7:0] host_addr = '0, host_wdata = '0;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_we;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       host;
    logic [7:0] rdata;
    int         cyc;
  } ack_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } mem_t;

  ack_t ack_q[$];
  mem_t mem_q[$];
  logic [7:0] ram [256];

  dmem_arbiter #(.AW(8), .DW(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .host_req  (host_req),
    .host_we   (host_we),
    .host_addr (host_addr),
    .host_wdata(host_wdata),
    .host_ack  (host_ack),
    .host_rdata(host_rdata),
    .host_lock (host_lock),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Synchronous RAM model; reset reloads the one preloaded word.
  always @(posedge CLK) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (RST) ram[8'h20] <= 8'h3C;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic push_ack(input logic host, input logic [7:0] rd, input int c);
    ack_t e;
    e.host = host; e.rdata = rd; e.cyc = c;
    ack_q.push_back(e);
  endtask

  task automatic push_mem(input logic [7:0] a, input logic [7:0] d, input int c);
    mem_t e;
    e.addr = a; e.data = d; e.cyc = c;
    mem_q.push_back(e);
  endtask

  // Monitor: every ack and every RAM write must match the head of its queue.
  always @(negedge CLK) begin
    if (cpu_ack && host_ack) chk("dual_ack", 32'(1), 32'(0));
    if (cpu_ack || host_ack) begin
      if (ack_q.size() == 0) begin
        chk("unexpected_ack", 32'({cpu_ack, host_ack}), 32'(0));
      end else begin
        ack_t e;
        e = ack_q.pop_front();
        chk("ack_owner", 32'(host_ack), 32'(e.host));
        chk("ack_cycle", 32'(cyc), 32'(e.cyc));
        chk("ack_rdata", 32'(host_ack ? host_rdata : cpu_rdata), 32'(e.rdata));
      end
    end
    if (mem_we) begin
      if (mem_q.size() == 0) begin
        chk("unexpected_mem_we", 32'(mem_addr), 32'(0));
      end else begin
        mem_t m;
        m = mem_q.pop_front();
        chk("mem_addr", 32'(mem_addr), 32'(m.addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(m.data));
        chk("mem_cycle", 32'(cyc), 32'(m.cyc));
      end
    end
  end

  // Single request from an idle arbiter: ack two cycles after the drive cycle.
  task automatic xfer(input logic host, input logic we, input logic [7:0] a,
                      input logic [7:0] wd, input logic [7:0] exp_rd);
    int k;
    k = cyc;
    if (host) begin
      host_req = 1'b1; host_we = we; host_addr = a; host_wdata = wd;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    end
    push_ack(host, exp_rd, k + 2);
    if (we) push_mem(a, wd, k + 1);
    tick;
    tick;
    cpu_req = 1'b0;
    host_req = 1'b0;
    tick;
  endtask

  initial begin
    int k;
    int r;
    tick;
    tick;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'(0));
    chk("rst_host_ack", 32'(host_ack), 32'(0));
    chk("rst_mem_we", 32'(mem_we), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
    chk("rst_host_rdata", 32'(host_rdata), 32'(0));
    tick;

    xfer(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00);  // CPU write, rdata holds reset value
    xfer(1'b1, 1'b0, 8'h20, 8'h00, 8'h3C);  // host read of preloaded word
    xfer(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);
    xfer(1'b1, 1'b1, 8'h21, 8'h99, 8'h3C);  // host write keeps previous host_rdata
    xfer(1'b0, 1'b0, 8'h21, 8'h00, 8'h99);

    // Lock rising during a CPU transaction does not abort it.
    k = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h22; cpu_wdata = 8'h11;
    push_ack(1'b0, 8'h99, k + 2);
    push_mem(8'h22, 8'h11, k + 1);
    tick;
    host_lock = 1'b1;
    tick;
    cpu_req = 1'b0;
    tick;
    host_lock = 1'b0;

    // CPU starved under host_lock, served once the lock drops.
    host_lock = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h22;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("lock_stall", 32'(cpu_stall), 32'(1));
      tick;
    end
    k = cyc;
    host_lock = 1'b0;
    push_ack(1'b0, 8'h11, k + 2);
    tick;
    tick;
    @(negedge CLK);
    chk("stall_at_ack", 32'(cpu_stall), 32'(0));
    cpu_req = 1'b0;
    tick;

    // Reset in ACCESS of a CPU write: abandoned, then the held request reruns.
    k = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h30; cpu_wdata = 8'h77;
    push_mem(8'h30, 8'h77, k + 1);
    tick;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_mem_we", 32'(mem_we), 32'(0));
    chk("post_rst_cpu_ack", 32'(cpu_ack), 32'(0));
    chk("post_rst_mem_addr", 32'(mem_addr), 32'(0));
    push_mem(8'h30, 8'h77, k + 3);
    push_ack(1'b0, 8'h00, k + 4);
    tick;
    tick;
    cpu_req = 1'b0;
    tick;

    // CPU drops req in ACCESS; host waiting behind it gets the next grant.
    k = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
    push_ack(1'b0, 8'h77, k + 2);
    tick;
    cpu_req = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h5A;
    push_mem(8'h40, 8'h5A, k + 4);
    push_ack(1'b1, 8'h00, k + 5);
    repeat (4) tick;
    host_req = 1'b0;
    tick;

    // Both requesting through and after reset: CPU, HOST, CPU, HOST.
    RST = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h40;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    tick;
    tick;
    RST = 1'b0;
    r = cyc;
    push_ack(1'b0, 8'h5A, r + 2);
    push_ack(1'b1, 8'h3C, r + 5);
    push_ack(1'b0, 8'h5A, r + 8);
    push_ack(1'b1, 8'h3C, r + 11);
    @(negedge CLK);
    chk("rr_rst_cpu_rdata", 32'(cpu_rdata), 32'(0));
    chk("rr_rst_host_rdata", 32'(host_rdata), 32'(0));
    repeat (11) tick;
    cpu_req = 1'b0;
    host_req = 1'b0;
    repeat (4) tick;

    chk("ack_queue_drained", 32'(ack_q.size()), 32'(0));
    chk("mem_queue_drained", 32'(mem_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters (name, default, meaning): AW, 8, data-memory address width; DW, 8, data-memory word width.
REQ-002 Ports (name, direction, width, meaning):
- CLK, in, 1, single clock; all state changes on rising edge.
- RST, in, 1, synchronous, active-high reset.
- cpu_req, in, 1, CPU access request; held until cpu_ack.
- cpu_we, in, 1, CPU write (1) / read (0).
- cpu_addr, in, AW, CPU address.
- cpu_wdata, in, DW, CPU write data.
- cpu_ack, out, 1, one-cycle completion pulse to CPU.
- cpu_rdata, out, DW, CPU read data; valid while cpu_ack=1.
- cpu_stall, out, 1, cpu_req & ~cpu_ack; freezes the control FSM.
- host_req, in, 1, host/loader access request; held until host_ack.
- host_we, in, 1, host write / read.
- host_addr, in, AW, host address.
- host_wdata, in, DW, host write data.
- host_ack, out, 1, one-cycle completion pulse to host.
- host_rdata, out, DW, host read data; valid while host_ack=1.
- host_lock, in, 1, host exclusive mode; CPU receives no grants while high.
- mem_addr, out, AW, RAM address.
- mem_wdata, out, DW, RAM write data.
- mem_we, out, 1, RAM write enable.
- mem_rdata, in, DW, RAM read data; synchronous RAM, valid one cycle after address.

Function
REQ-003 FSM states: IDLE, ACCESS, DONE; no other reachable state; illegal encodings return to IDLE next cycle.
REQ-004 IDLE: if any eligible request, select winner, register its we/addr/wdata and owner, go to ACCESS; else stay IDLE.
REQ-005 Eligibility: host eligible when host_req=1; CPU eligible when cpu_req=1 and host_lock=0.
REQ-006 Single eligible requester wins; both eligible -> requester not granted last (round-robin bit last_grant), last_grant updated on every grant.
REQ-007 ACCESS: mem_addr/mem_wdata driven from registered values; mem_we = registered we for exactly this cycle; next state DONE.
REQ-008 DONE: ack of owner = 1 for exactly one cycle; owner rdata = mem_rdata if read, holds previous value if write; next state IDLE.
REQ-009 Latency: request sampled in IDLE at cycle N -> mem_we/address at N+1 -> ack at N+2; max throughput one access per 3 cycles.
REQ-010 Outside ACCESS, mem_we = 0; mem_addr/mem_wdata hold last registered values.
REQ-011 cpu_ack and host_ack never asserted in the same cycle; at most one ack per grant.
REQ-012 Request inputs ignored in ACCESS and DONE; inputs changed after grant do not alter the transaction in flight.
REQ-013 Request deasserted after grant (protocol violation): transaction still completes and ack still pulses.
REQ-014 Requester holding req in the cycle after its ack is treated as a new request in IDLE.
REQ-015 host_lock rising during a CPU transaction does not abort it; lock applies from the next IDLE decision.
REQ-016 cpu_stall combinational: 1 while cpu_req=1 and cpu_ack=0, including during host_lock.

Reset
REQ-017 RST=1 at a rising edge: state=IDLE, mem_we=0, cpu_ack=0, host_ack=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, host_rdata=0, last_grant=HOST (CPU wins first tie).
REQ-018 RST mid-transaction: transaction abandoned, no ack issued, no mem_we pulse in the cycle after reset.
REQ-019 Reset dominates all inputs; requests held through reset are arbitrated starting the first cycle after RST falls.

Verification
REQ-020 CPU write addr=0x10 data=0xA5 -> mem_we=1, mem_addr=0x10, mem_wdata=0xA5 at N+1; cpu_ack=1 at N+2; mem_we=0 at N+2.
REQ-021 RAM preloaded 0x3C at 0x20, host read 0x20 -> host_ack=1, host_rdata=0x3C at N+2; cpu_ack stays 0.
REQ-022 Both requesting continuously from reset -> grant order CPU, HOST, CPU, HOST; acks at cycles 2, 5, 8, 11.
REQ-023 host_lock=1 with cpu_req=1 for 20 cycles and host idle -> no cpu_ack, cpu_stall=1 throughout; lock drop -> cpu_ack 3 cycles later.
REQ-024 RST pulsed in ACCESS of a CPU write -> no cpu_ack, mem_we=0 after reset, held cpu_req completes 3 cycles after RST falls.
REQ-025 cpu_req dropped in ACCESS -> cpu_ack still pulses once; next IDLE grants host if requesting.
